// File: rtl/branch_resolver_if.sv
// Predict/resolve bus between IF, EX and the branch resolver; BRANCH_RESOLVER_STATS_EN adds stat outputs.
// Master drives predictions and EX operands; slave returns outcome, redirect and flush.
interface branch_resolver_if #(
  parameter int PC_SIZE = 12
);
  logic               pred_valid;
  logic               pred_taken;
  logic [PC_SIZE-1:0] pred_target;
  logic [PC_SIZE-1:0] pred_fallthrough;
  logic               resolve_valid;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [31:0]        rs1_data;
  logic [31:0]        rs2_data;
  logic               should_have_jumped;
  logic               mispredict;
  logic [PC_SIZE-1:0] redirect_pc;
  logic               flush;
  logic               queue_error;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispredicts;
`endif

  modport master (
`ifdef BRANCH_RESOLVER_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    output pred_valid, pred_taken, pred_target, pred_fallthrough,
    output resolve_valid, opcode, funct3, rs1_data, rs2_data,
    input  should_have_jumped, mispredict, redirect_pc, flush, queue_error
  );

  modport slave (
`ifdef BRANCH_RESOLVER_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    input  pred_valid, pred_taken, pred_target, pred_fallthrough,
    input  resolve_valid, opcode, funct3, rs1_data, rs2_data,
    output should_have_jumped, mispredict, redirect_pc, flush, queue_error
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-side branch resolver: outcome/mispredict/redirect registered 1 cycle after resolve; no backpressure,
// push-on-full drops and pop-on-empty flag sticky queue_error. BRANCH_RESOLVER_STATS_EN adds counters.
module branch_resolver #(
  parameter int PC_SIZE      = 12,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              CLK,
  input logic              RESET,
  branch_resolver_if.slave br
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic               taken;
    logic [PC_SIZE-1:0] target;
    logic [PC_SIZE-1:0] fallthrough;
  } entry_t;

  typedef enum logic [0:0] {S_IDLE, S_FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  entry_t          mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full;
  entry_t          incoming, entry;
  logic            is_br, actual;
  logic            do_push, do_pop, rd_adv, clear_q, err_set, cmp, mis_nxt;
  logic            shj_q, mis_q, qerr_q;
  logic [PC_SIZE-1:0] rpc_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign incoming = '{taken: br.pred_taken, target: br.pred_target, fallthrough: br.pred_fallthrough};

  always_comb begin
    is_br  = 1'b0;
    actual = 1'b0;
    if (br.opcode == OP_JAL) begin
      is_br  = 1'b1;
      actual = 1'b1;
    end else if (br.opcode == OP_BRANCH) begin
      is_br = 1'b1;
      case (br.funct3)
        3'b000:  actual = (br.rs1_data == br.rs2_data);
        3'b001:  actual = (br.rs1_data != br.rs2_data);
        3'b100:  actual = ($signed(br.rs1_data) <  $signed(br.rs2_data));
        3'b101:  actual = ($signed(br.rs1_data) >= $signed(br.rs2_data));
        3'b110:  actual = (br.rs1_data <  br.rs2_data);
        3'b111:  actual = (br.rs1_data >= br.rs2_data);
        default: actual = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    rd_adv    = 1'b0;
    clear_q   = 1'b0;
    err_set   = 1'b0;
    cmp       = 1'b0;
    mis_nxt   = 1'b0;
    entry     = '0;
    case (state)
      S_IDLE: begin
        do_pop  = br.resolve_valid && is_br;
        // A pop on full frees the slot the incoming push reuses
        do_push = br.pred_valid && (!full || do_pop);
        rd_adv  = do_pop && (!empty || br.pred_valid);
        err_set = (br.pred_valid && full && !do_pop) || (do_pop && empty && !br.pred_valid);
        if (do_pop) begin
          cmp = 1'b1;
          if (!empty)             entry = mem[rd_ptr[AW-1:0]];
          else if (br.pred_valid) entry = incoming;
          mis_nxt = (actual != entry.taken);
          if (mis_nxt) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = CW'(FLUSH_CYCLES - 1);
            clear_q   = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      shj_q  <= 1'b0;
      mis_q  <= 1'b0;
      rpc_q  <= '0;
      qerr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mis_q <= mis_nxt;
      if (err_set) qerr_q <= 1'b1;
      if (cmp)     shj_q  <= actual;
      if (mis_nxt) rpc_q  <= actual ? entry.target : entry.fallthrough;
      // Everything still queued is younger than the mispredicted branch
      if (clear_q) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (rd_adv)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && do_push && !clear_q) mem[wr_ptr[AW-1:0]] <= incoming;
  end

  assign br.should_have_jumped = shj_q;
  assign br.mispredict         = mis_q;
  assign br.redirect_pc        = rpc_q;
  assign br.flush              = (state == S_FLUSH);
  assign br.queue_error        = qerr_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (cmp && stat_br_q != 32'hFFFF_FFFF)      stat_br_q  <= stat_br_q + 32'd1;
      if (mis_nxt && stat_mis_q != 32'hFFFF_FFFF) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign br.stat_branches    = stat_br_q;
  assign br.stat_mispredicts = stat_mis_q;
`endif
endmodule
